// File: rtl/nibble_alu_seq.sv
// Sequences a W-bit operation through an external combinational 4-bit ALU, one nibble per cycle.
// Owns all operand, carry and result state; the ALU pins are driven only while running.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for i_start; ALU disabled, result held
// S_RUN  | one nibble per cycle through the ALU, r_idx = current nibble
// S_DONE | o_done pulse for one cycle, then back to S_IDLE
module nibble_alu_seq #(
    parameter int NIBBLES = 4,
    localparam int W  = 4 * NIBBLES,
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [2:0]   i_op,
    input  logic [W-1:0] i_opa,
    input  logic [W-1:0] i_opb,
    input  logic         i_cin,
    output logic         o_busy,
    output logic         o_done,
    output logic [W-1:0] o_result,
    output logic         o_carry_out,
    output logic [3:0]   o_alu_a,
    output logic [3:0]   o_alu_b,
    output logic         o_alu_cin,
    output logic         o_alu_sel0,
    output logic         o_alu_sel1,
    output logic         o_alu_sel2,
    output logic         o_alu_enable,
    input  logic [3:0]   i_alu_out,
    input  logic         i_alu_cout
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [IW-1:0]  r_idx;
    logic [W-1:0]   r_opa;
    logic [W-1:0]   r_opb;
    logic [2:0]     r_op;
    logic           r_cin;
    logic           r_carry;
    logic [W-1:0]   r_result;
    logic           r_carry_out;

    logic           w_last;
    logic           w_is_add;
    logic [3:0]     w_a_nib;
    logic [3:0]     w_b_nib;

    assign w_last   = (r_idx == IW'(NIBBLES - 1));
    assign w_is_add = (r_op == 3'b000);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_state_nxt = S_RUN;
            S_RUN:   if (w_last)  w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_idx       <= '0;
            r_opa       <= '0;
            r_opb       <= '0;
            r_op        <= '0;
            r_cin       <= 1'b0;
            r_carry     <= 1'b0;
            r_result    <= '0;
            r_carry_out <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_opa       <= i_opa;
                        r_opb       <= i_opb;
                        r_op        <= i_op;
                        r_cin       <= i_cin;
                        r_carry     <= 1'b0;
                        r_result    <= '0;
                        r_carry_out <= 1'b0;
                        r_idx       <= '0;
                    end
                end
                S_RUN: begin
                    for (int n = 0; n < NIBBLES; n++) begin
                        if (r_idx == IW'(n)) r_result[4*n +: 4] <= i_alu_out;
                    end
                    r_carry <= i_alu_cout;
                    // wrap explicitly so non-power-of-two NIBBLES never walks past the top nibble
                    r_idx   <= w_last ? '0 : r_idx + IW'(1);
                    if (w_last) r_carry_out <= w_is_add & i_alu_cout;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_a_nib = '0;
        w_b_nib = '0;
        for (int n = 0; n < NIBBLES; n++) begin
            if (r_idx == IW'(n)) begin
                w_a_nib = r_opa[4*n +: 4];
                w_b_nib = r_opb[4*n +: 4];
            end
        end
    end

    // ALU pins are parked (disabled, all zero) whenever we are not running
    always_comb begin
        o_alu_a      = '0;
        o_alu_b      = '0;
        o_alu_cin    = 1'b0;
        o_alu_sel0   = 1'b0;
        o_alu_sel1   = 1'b0;
        o_alu_sel2   = 1'b0;
        o_alu_enable = 1'b1;
        if (r_state == S_RUN) begin
            o_alu_a      = w_a_nib;
            o_alu_b      = w_b_nib;
            o_alu_cin    = w_is_add & ((r_idx == '0) ? r_cin : r_carry);
            o_alu_sel0   = r_op[0];
            o_alu_sel1   = r_op[1];
            o_alu_sel2   = r_op[2];
            o_alu_enable = 1'b0;
        end
    end

    assign o_busy      = (r_state != S_IDLE);
    assign o_done      = (r_state == S_DONE);
    assign o_result    = r_result;
    assign o_carry_out = r_carry_out;

endmodule

// File: doc/nibble_alu_seq.md
# nibble_alu_seq

Sequencer that sits directly upstream of the 4-bit ALU slice and runs 16-bit operations through it one nibble per cycle. It latches wide operands and an opcode, drives the ALU's operand, carry-in, select and enable pins, and captures each nibble result and carry into a result register. It pulses `done` when the full word is ready. The ALU itself stays combinational and external; this block owns all state.

## Interface

Parameters:
- `NIBBLES`, default 4: number of 4-bit slices per operation. Operand/result width W = 4*NIBBLES.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: request; sampled only in IDLE.
- `op`  in  3: ALU opcode {sel2,sel1,sel0}. 000 add, 001 and, 010 or, 011 nand, 100 nor, 101–111 reserved (ALU returns 0).
- `opa`, `opb`  in  W: operands, sampled with `start`.
- `cin`  in  1: add carry-in, sampled with `start`.
- `busy`  out  1: high whenever state != IDLE.
- `done`  out  1: one-cycle pulse, result valid.
- `result`  out  W: registered result; holds until the next accepted start.
- `carry_out`  out  1: final carry of an add; 0 for every other opcode.
- `alu_a`, `alu_b`  out  4: current operand nibbles.
- `alu_cin`  out  1: ALU carry-in.
- `alu_sel0`, `alu_sel1`, `alu_sel2`  out  1: ALU select, = op_reg[0], [1], [2].
- `alu_enable`  out  1: ALU enable, active-low. 0 = ALU active, 1 = ALU output forced 0.
- `alu_out`  in  4: ALU result nibble.
- `alu_cout`  in  1: ALU carry-out.

## Operation

- State machine: IDLE, RUN, DONE.
  - IDLE: `start`=1 latches `opa`, `opb`, `op`, `cin` into internal registers. It clears `result`, `carry_out` and the carry register, sets idx=0, and moves to RUN.
  - RUN: the ALU is driven combinationally from registers.
    - `alu_a` = opa_reg[4*idx+3:4*idx], `alu_b` likewise from opb_reg.
    - `alu_enable`=0.
    - `alu_cin` = (op_reg==000) ? (idx==0 ? cin_reg : carry_reg) : 0.
  - RUN, each edge: result[4*idx+3:4*idx] <= `alu_out`; carry_reg <= `alu_cout`; idx <= idx+1. On the edge where idx==NIBBLES-1, move to DONE, and `carry_out` <= (op_reg==000) ? `alu_cout` : 0.
  - DONE: `done`=1 for exactly this cycle, then IDLE unconditionally.
- Outside RUN: `alu_enable`=1, and `alu_a`, `alu_b`, `alu_cin` and `alu_sel*` are 0.
- `start` in RUN or DONE is ignored and not queued. `start` in the same cycle the block returns from DONE is also ignored, because the state is not yet IDLE.
- Reserved opcodes run the full sequence: result 0, `carry_out` 0.
- idx width is ceil(log2(NIBBLES)), minimum 1; it is never compared beyond NIBBLES-1. Add arithmetic is unsigned modulo 2^W, and the overflow goes to `carry_out`.

## Timing

- Reset (asynchronous, immediate, also mid-RUN): state IDLE, idx 0, `busy` 0, `done` 0, `result` 0, `carry_out` 0, all operand/op/carry registers 0, `alu_enable` 1, `alu_a`/`alu_b`/`alu_cin`/`alu_sel*` 0. No partial result survives a reset.
- `start` sampled at edge T. RUN occupies cycles T+1 … T+NIBBLES. `done`=1 in cycle T+NIBBLES+1.
- `result`/`carry_out` are final and stable from cycle T+NIBBLES+1 until the next accepted start.
- Latency start→done = NIBBLES+1 cycles. Throughput is one operation per NIBBLES+2 cycles.
- `busy` rises in cycle T+1 and falls after the DONE cycle. The earliest next accepted `start` is at edge T+NIBBLES+2.
- Partial nibbles are visible on `result` during RUN and are not valid until `done`.

## Test plan

Bench uses a behavioural model of the 4-bit ALU on the alu_* pins; NIBBLES=4.

- add, `opa`=0x1234, `opb`=0x0FFF, `cin`=0 → `result`=0x2233, `carry_out`=0; `done` exactly 5 cycles after the start edge.
- add, `opa`=0xFFFF, `opb`=0x0000, `cin`=1 → carry ripples through all nibbles: `result`=0x0000, `carry_out`=1; `alu_cin` is 1 in every RUN cycle.
- and, 0xF0F0 & 0x3C3C → 0x3030. nand of the same operands → 0xCFCF. nor, 0x0000,0x0000 → 0xFFFF. All with `carry_out`=0, `cin`=1 ignored.
- op=110, any operands → `result`=0x0000, `carry_out`=0; `alu_enable`=0 only during the 4 RUN cycles.
- `start` held high continuously with changing operands → one operation every 6 cycles, each using operands sampled only at accepted edges; no `done` pulse is missed or doubled.
- `rst` asserted mid-RUN at idx=2 → in the same cycle `busy`=0, `result`=0, `alu_enable`=1. A new add afterwards completes with a correct result.
